multicycle_ctrl_v2: RTL and testbench

- Next-generation multicycle control unit for the MIPS datapath.
- Sequences IF/ID/EXE/MEM/WB per instruction and drives all datapath control strobes.
- New over the previous generation: memory wait-state handshake, a HALT state, illegal-opcode trap, saturating retired-instruction counter, and parametrised ALUOp/counter widths.
- Sits between the instruction register decode fields and the datapath (PC, register file, ALU, data memory).

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/ctrl_decode.sv | 84 ++++++++
 rtl/multicycle_ctrl_v2.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_ctrl_v2.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// states, opcodes, function codes, ALUOp and mux select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_WB   = 3'b011,
    S_MEM  = 3'b100,
    S_HALT = 3'b101
  } state_t;

  typedef enum logic [3:0] {
    C_RALU, C_IALU, C_LW, C_SW, C_BEQ,
    C_BLTZ, C_J, C_JAL, C_JR, C_NONE
  } iclass_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;

  localparam logic [1:0] RD_31 = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  localparam logic [1:0] PC_4   = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_RS  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/func decoder: instruction class,
// operand selects, base ALU function and legality.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output iclass_t    cls,
  output logic       ext_sel,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    cls       = C_NONE;
    ext_sel   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    legal     = 1'b1;
    unique case (1'b1)
      (op == OP_R): begin
        cls = C_RALU;
        unique case (1'b1)
          (func == F_ADD): alu_op = ALU_ADD;
          (func == F_SUB): alu_op = ALU_SUB;
          (func == F_AND): alu_op = ALU_AND;
          (func == F_OR):  alu_op = ALU_OR;
          (func == F_SLT): alu_op = ALU_SLT;
          (func == F_SLL): begin
            alu_op    = ALU_SLL;
            alu_src_a = 1'b1;
          end
          (func == F_JR): cls = C_JR;
          default: begin
            cls   = C_NONE;
            legal = 1'b0;
          end
        endcase
      end
      (op == OP_ADDI): begin
        cls       = C_IALU;
        ext_sel   = 1'b1;
        alu_src_b = 1'b1;
      end
      (op == OP_ORI): begin
        cls       = C_IALU;
        alu_src_b = 1'b1;
        alu_op    = ALU_OR;
      end
      (op == OP_SLTIU): begin
        cls       = C_IALU;
        alu_src_b = 1'b1;
        alu_op    = ALU_SLTU;
      end
      (op == OP_LW): begin
        cls       = C_LW;
        ext_sel   = 1'b1;
        alu_src_b = 1'b1;
      end
      (op == OP_SW): begin
        cls       = C_SW;
        ext_sel   = 1'b1;
        alu_src_b = 1'b1;
      end
      (op == OP_BEQ): begin
        cls     = C_BEQ;
        ext_sel = 1'b1;
        alu_op  = ALU_SUB;
      end
      (op == OP_BLTZ): begin
        cls     = C_BLTZ;
        ext_sel = 1'b1;
        alu_op  = ALU_SUB;
      end
      (op == OP_J):   cls = C_J;
      (op == OP_JAL): cls = C_JAL;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM with memory wait states,
// HALT/illegal trap and saturating retired-instruction counter.
module multicycle_ctrl_v2
  import ctrl_pkg::*;
#(
  parameter int          ALUOP_W     = 4,
  parameter int          CNT_W       = 32,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter logic [5:0]  HALT_OP     = 6'b111111
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               sign,
  input  logic               mem_ready,
  output logic               IRWre,
  output logic               PCWre,
  output logic               ExtSel,
  output logic               InsMemRW,
  output logic               WrRegDSrc,
  output logic               RegWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               mRD,
  output logic               mWR,
  output logic               DBDataSrc,
  output logic [1:0]         RegDst,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         state_o,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retire_cnt
);

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic             w_set_ill;
  logic             w_rdy;

  iclass_t    w_cls;
  logic       w_ext;
  logic       w_src_a;
  logic       w_src_b;
  logic [3:0] w_alu;
  logic       w_legal;

  ctrl_decode u_dec (
    .op        (op),
    .func      (func),
    .cls       (w_cls),
    .ext_sel   (w_ext),
    .alu_src_a (w_src_a),
    .alu_src_b (w_src_b),
    .alu_op    (w_alu),
    .legal     (w_legal)
  );

  assign w_rdy      = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state_o    = r_state;
  assign halted     = (r_state == S_HALT);
  assign illegal    = r_illegal;
  assign retire_cnt = r_cnt;

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    IRWre     = 1'b0;
    PCWre     = 1'b0;
    ExtSel    = 1'b0;
    InsMemRW  = 1'b0;
    WrRegDSrc = 1'b0;
    RegWre    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    mRD       = 1'b0;
    mWR       = 1'b0;
    DBDataSrc = 1'b0;
    RegDst    = RD_31;
    PCSrc     = PC_4;
    ALUOp     = '0;
    // Every strobe is forced low while reset is held
    if (!RST && r_state != S_HALT) begin
      ExtSel = w_ext;
      ALUOp  = ALUOP_W'(w_alu);
      case (r_state)
        S_IF: begin
          InsMemRW = 1'b1;
          if (w_rdy) begin
            IRWre  = 1'b1;
            w_next = S_ID;
          end
        end
        S_ID: begin
          w_next = S_EXE;
          if (op == HALT_OP) begin
            w_next = S_HALT;
          end else if (!w_legal) begin
            w_next    = S_HALT;
            w_set_ill = 1'b1;
          end else begin
            case (w_cls)
              C_J: begin
                PCWre  = 1'b1;
                PCSrc  = PC_JMP;
                w_next = S_IF;
              end
              C_JAL: begin
                PCWre  = 1'b1;
                PCSrc  = PC_JMP;
                RegWre = 1'b1;
                RegDst = RD_31;
                w_next = S_IF;
              end
              C_JR: begin
                PCWre  = 1'b1;
                PCSrc  = PC_RS;
                w_next = S_IF;
              end
              default: ;
            endcase
          end
        end
        S_EXE: begin
          ALUSrcA = w_src_a;
          ALUSrcB = w_src_b;
          case (w_cls)
            C_BEQ: begin
              PCWre  = 1'b1;
              PCSrc  = zero ? PC_BR : PC_4;
              w_next = S_IF;
            end
            C_BLTZ: begin
              PCWre  = 1'b1;
              PCSrc  = sign ? PC_BR : PC_4;
              w_next = S_IF;
            end
            C_LW, C_SW: w_next = S_MEM;
            default:    w_next = S_WB;
          endcase
        end
        S_MEM: begin
          mRD = (w_cls == C_LW);
          if (w_rdy) begin
            if (w_cls == C_SW) begin
              mWR    = 1'b1;
              PCWre  = 1'b1;
              w_next = S_IF;
            end else begin
              w_next = S_WB;
            end
          end
        end
        S_WB: begin
          RegWre    = 1'b1;
          PCWre     = 1'b1;
          DBDataSrc = (w_cls == C_LW);
          WrRegDSrc = (w_cls == C_LW);
          RegDst    = (w_cls == C_RALU) ? RD_RD : RD_RT;
          w_next    = S_IF;
        end
        default: w_next = S_IF;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IF;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_ill)
        r_illegal <= 1'b1;
      if (PCWre && r_cnt != '1)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Directed self-checking bench for multicycle_ctrl_v2
// (4-bit counter instance so saturation is reachable).
module tb_multicycle_ctrl_v2;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] op, func;
  logic       zero, sign, mem_ready;
  logic       IRWre, PCWre, ExtSel, InsMemRW, WrRegDSrc;
  logic       RegWre, ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [3:0] ALUOp;
  logic [2:0] state_o;
  logic       halted, illegal;
  logic [3:0] retire_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl_v2 #(
    .ALUOP_W(4), .CNT_W(4),
    .MEM_WAIT_EN(1'b1), .HALT_OP(6'b111111)
  ) dut (
    .CLK(CLK), .RST(RST), .op(op), .func(func),
    .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .IRWre(IRWre), .PCWre(PCWre), .ExtSel(ExtSel),
    .InsMemRW(InsMemRW), .WrRegDSrc(WrRegDSrc),
    .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
    .RegDst(RegDst), .PCSrc(PCSrc), .ALUOp(ALUOp),
    .state_o(state_o), .halted(halted), .illegal(illegal),
    .retire_cnt(retire_cnt)
  );

  function automatic logic [18:0] strobes();
    return {IRWre, PCWre, ExtSel, InsMemRW, WrRegDSrc,
            RegWre, ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc,
            RegDst, PCSrc, ALUOp};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic retire();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic test_reset();
    RST = 1'b1; op = 6'b0; func = 6'b100000;
    zero = 0; sign = 0; mem_ready = 1;
    #12;
    n_chk++;
    if (state_o !== 3'b000) begin
      n_fail++; $display("FAIL rst_state got %b want 000", state_o);
    end
    n_chk++;
    if (strobes() !== 19'b0) begin
      n_fail++; $display("FAIL rst_strobes got %b want 0", strobes());
    end
    n_chk++;
    if (retire_cnt !== 4'd0 || illegal !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_regs got cnt=%0d ill=%b halt=%b want 0/0/0",
               retire_cnt, illegal, halted);
    end
    RST = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_addi();
    op = 6'b001000; mem_ready = 1;
    #1;
    n_chk++;
    if (state_o !== 3'b000 || InsMemRW !== 1 || IRWre !== 1) begin
      n_fail++;
      $display("FAIL addi_if got st=%b imrw=%b irw=%b want 000/1/1",
               state_o, InsMemRW, IRWre);
    end
    tick();
    n_chk++;
    if (state_o !== 3'b001 || IRWre !== 0) begin
      n_fail++; $display("FAIL addi_id got st=%b irw=%b want 001/0", state_o, IRWre);
    end
    tick();
    n_chk++;
    if (state_o !== 3'b010 || ALUSrcB !== 1 || ALUSrcA !== 0) begin
      n_fail++;
      $display("FAIL addi_exe got st=%b srcA=%b srcB=%b want 010/0/1",
               state_o, ALUSrcA, ALUSrcB);
    end
    tick();
    n_chk++;
    if ({state_o, RegWre, PCWre, RegDst, ALUOp, ExtSel}
        !== {3'b011, 1'b1, 1'b1, 2'b01, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL addi_wb got st=%b rw=%b pcw=%b rd=%b alu=%b ext=%b",
               state_o, RegWre, PCWre, RegDst, ALUOp, ExtSel);
    end
    n_chk++;
    if (retire_cnt !== 4'(exp_cnt)) begin
      n_fail++; $display("FAIL addi_cnt_pre got %0d want %0d", retire_cnt, exp_cnt);
    end
    tick(); retire();
    n_chk++;
    if (state_o !== 3'b000 || retire_cnt !== 4'(exp_cnt)) begin
      n_fail++;
      $display("FAIL addi_done got st=%b cnt=%0d want 000/%0d",
               state_o, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_rst_mid_exe();
    op = 6'b001000; mem_ready = 1;
    tick(); tick();
    n_chk++;
    if (state_o !== 3'b010) begin
      n_fail++; $display("FAIL rexe_pre got %b want 010", state_o);
    end
    #2; RST = 1'b1; #1;
    n_chk++;
    if (state_o !== 3'b000 || retire_cnt !== 4'd0 || strobes() !== 19'b0) begin
      n_fail++;
      $display("FAIL rexe_async got st=%b cnt=%0d str=%b want 000/0/0",
               state_o, retire_cnt, strobes());
    end
    #2; RST = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_lw();
    op = 6'b100011; mem_ready = 1;
    tick(); tick(); tick();
    mem_ready = 0; #1;
    n_chk++;
    if ({state_o, mRD, mWR, PCWre} !== {3'b100, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL lw_mem1 got st=%b rd=%b wr=%b pcw=%b want 100/1/0/0",
               state_o, mRD, mWR, PCWre);
    end
    tick();
    n_chk++;
    if (state_o !== 3'b100 || mRD !== 1) begin
      n_fail++; $display("FAIL lw_mem2 got st=%b rd=%b want 100/1", state_o, mRD);
    end
    tick();
    mem_ready = 1; #1;
    n_chk++;
    if (state_o !== 3'b100 || mRD !== 1) begin
      n_fail++; $display("FAIL lw_mem3 got st=%b rd=%b want 100/1", state_o, mRD);
    end
    tick();
    n_chk++;
    if ({state_o, DBDataSrc, WrRegDSrc, RegWre, RegDst}
        !== {3'b011, 1'b1, 1'b1, 1'b1, 2'b01}) begin
      n_fail++;
      $display("FAIL lw_wb got st=%b db=%b wrs=%b rw=%b rd=%b",
               state_o, DBDataSrc, WrRegDSrc, RegWre, RegDst);
    end
    tick(); retire();
    n_chk++;
    if (state_o !== 3'b000 || retire_cnt !== 4'(exp_cnt)) begin
      n_fail++;
      $display("FAIL lw_7cyc got st=%b cnt=%0d want 000/%0d",
               state_o, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_sw();
    op = 6'b101011; mem_ready = 0; #1;
    n_chk++;
    if (IRWre !== 0 || InsMemRW !== 1) begin
      n_fail++; $display("FAIL sw_ifwait got irw=%b imrw=%b want 0/1", IRWre, InsMemRW);
    end
    tick();
    n_chk++;
    if (state_o !== 3'b000) begin
      n_fail++; $display("FAIL sw_ifhold got %b want 000", state_o);
    end
    mem_ready = 1;
    tick(); tick();
    n_chk++;
    if (ALUSrcB !== 1 || ExtSel !== 1) begin
      n_fail++; $display("FAIL sw_exe got srcB=%b ext=%b want 1/1", ALUSrcB, ExtSel);
    end
    tick();
    mem_ready = 0; #1;
    n_chk++;
    if ({state_o, mWR, mRD, PCWre} !== {3'b100, 3'b000}) begin
      n_fail++;
      $display("FAIL sw_memwait got st=%b wr=%b rd=%b pcw=%b want 100/0/0/0",
               state_o, mWR, mRD, PCWre);
    end
    tick();
    mem_ready = 1; #1;
    n_chk++;
    if (mWR !== 1 || PCWre !== 1) begin
      n_fail++; $display("FAIL sw_write got wr=%b pcw=%b want 1/1", mWR, PCWre);
    end
    tick(); retire();
    n_chk++;
    if (state_o !== 3'b000 || retire_cnt !== 4'(exp_cnt)) begin
      n_fail++;
      $display("FAIL sw_done got st=%b cnt=%0d want 000/%0d",
               state_o, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_branch();
    logic [5:0] t_op [5];
    logic       t_z  [5];
    logic       t_s  [5];
    logic [1:0] t_pc [5];
    t_op = '{6'b000100, 6'b000100, 6'b000100, 6'b000001, 6'b000001};
    t_z  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t_s  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t_pc = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      op = t_op[i]; zero = t_z[i]; sign = t_s[i];
      tick(); tick();
      n_chk++;
      if ({state_o, PCWre, PCSrc, ALUOp, ExtSel}
          !== {3'b010, 1'b1, t_pc[i], 4'b0001, 1'b1}) begin
        n_fail++;
        $display("FAIL br%0d got st=%b pcw=%b pcs=%b alu=%b ext=%b want pcs=%b",
                 i, state_o, PCWre, PCSrc, ALUOp, ExtSel, t_pc[i]);
      end
      tick(); retire();
      n_chk++;
      if (state_o !== 3'b000 || retire_cnt !== 4'(exp_cnt)) begin
        n_fail++;
        $display("FAIL br%0d_done got st=%b cnt=%0d want 000/%0d",
                 i, state_o, retire_cnt, exp_cnt);
      end
    end
    zero = 0; sign = 0;
  endtask

  task automatic test_jump();
    logic [5:0] t_op [3];
    logic [5:0] t_fn [3];
    logic [1:0] t_pc [3];
    logic       t_rw [3];
    t_op = '{6'b000010, 6'b000011, 6'b000000};
    t_fn = '{6'b000000, 6'b000000, 6'b001000};
    t_pc = '{2'b11, 2'b11, 2'b10};
    t_rw = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      op = t_op[i]; func = t_fn[i];
      tick();
      n_chk++;
      if ({state_o, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc}
          !== {3'b001, 1'b1, t_pc[i], t_rw[i], 2'b00, 1'b0}) begin
        n_fail++;
        $display("FAIL jmp%0d got st=%b pcw=%b pcs=%b rw=%b rd=%b wrs=%b",
                 i, state_o, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc);
      end
      tick(); retire();
      n_chk++;
      if (state_o !== 3'b000 || retire_cnt !== 4'(exp_cnt)) begin
        n_fail++;
        $display("FAIL jmp%0d_done got st=%b cnt=%0d want 000/%0d",
                 i, state_o, retire_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [5:0] t_op  [8];
    logic [5:0] t_fn  [8];
    logic [3:0] t_alu [8];
    logic       t_sa  [8];
    logic       t_sb  [8];
    logic [1:0] t_rd  [8];
    t_op  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
              6'b001101, 6'b001011};
    t_fn  = '{6'b100010, 6'b000000, 6'b100100, 6'b101010,
              6'b100101, 6'b100000, 6'b000000, 6'b000000};
    t_alu = '{4'b0001, 4'b0100, 4'b0110, 4'b0011,
              4'b0101, 4'b0000, 4'b0101, 4'b0010};
    t_sa  = '{0, 1, 0, 0, 0, 0, 0, 0};
    t_sb  = '{0, 0, 0, 0, 0, 0, 1, 1};
    t_rd  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 8; i++) begin
      op = t_op[i]; func = t_fn[i];
      tick(); tick();
      n_chk++;
      if ({state_o, ALUOp, ALUSrcA, ALUSrcB}
          !== {3'b010, t_alu[i], t_sa[i], t_sb[i]}) begin
        n_fail++;
        $display("FAIL alu%0d_exe got st=%b alu=%b sa=%b sb=%b want %b/%b/%b",
                 i, state_o, ALUOp, ALUSrcA, ALUSrcB, t_alu[i], t_sa[i], t_sb[i]);
      end
      if (t_op[i] != 6'h00) begin
        n_chk++;
        if (ExtSel !== 1'b0) begin
          n_fail++; $display("FAIL alu%0d_ext got %b want 0", i, ExtSel);
        end
      end
      tick();
      n_chk++;
      if ({state_o, RegDst, RegWre, DBDataSrc}
          !== {3'b011, t_rd[i], 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL alu%0d_wb got st=%b rd=%b rw=%b db=%b want rd=%b",
                 i, state_o, RegDst, RegWre, DBDataSrc, t_rd[i]);
      end
      tick(); retire();
      n_chk++;
      if (retire_cnt !== 4'(exp_cnt)) begin
        n_fail++; $display("FAIL alu%0d_cnt got %0d want %0d", i, retire_cnt, exp_cnt);
      end
    end
  endtask

  task automatic test_rst_mid_mem();
    op = 6'b101011; mem_ready = 1;
    tick(); tick(); tick();
    #1;
    n_chk++;
    if (state_o !== 3'b100 || mWR !== 1) begin
      n_fail++; $display("FAIL rmem_pre got st=%b wr=%b want 100/1", state_o, mWR);
    end
    RST = 1'b1; #1;
    n_chk++;
    if ({mWR, PCWre, state_o, retire_cnt} !== {1'b0, 1'b0, 3'b000, 4'd0}) begin
      n_fail++;
      $display("FAIL rmem_async got wr=%b pcw=%b st=%b cnt=%0d want 0/0/000/0",
               mWR, PCWre, state_o, retire_cnt);
    end
    #2; RST = 1'b0;
    exp_cnt = 0;
    op = 6'b000010;
    tick();
    n_chk++;
    if (retire_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rmem_noret got %0d want 0", retire_cnt);
    end
    tick(); retire();
  endtask

  task automatic test_saturation();
    op = 6'b000010; mem_ready = 1;
    for (int i = 0; i < 14; i++) begin
      tick(); tick(); retire();
    end
    n_chk++;
    if (retire_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_full got %0d want 15", retire_cnt);
    end
    tick();
    n_chk++;
    if (PCWre !== 1'b1) begin
      n_fail++; $display("FAIL sat_pcw got %b want 1", PCWre);
    end
    tick(); retire();
    n_chk++;
    if (retire_cnt !== 4'(exp_cnt) || retire_cnt !== 4'd15) begin
      n_fail++; $display("FAIL sat_hold got %0d want 15", retire_cnt);
    end
  endtask

  task automatic test_halt();
    op = 6'b111111; mem_ready = 1;
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      op = (i % 2 == 0) ? 6'b001000 : 6'b000010;
      mem_ready = i[0];
      #1;
      n_chk++;
      if ({state_o, halted, illegal, strobes(), retire_cnt}
          !== {3'b101, 1'b1, 1'b0, 19'b0, 4'(exp_cnt)}) begin
        n_fail++;
        $display("FAIL halt_c%0d got st=%b h=%b ill=%b str=%b cnt=%0d",
                 i, state_o, halted, illegal, strobes(), retire_cnt);
      end
      tick();
    end
    RST = 1'b1; #1;
    n_chk++;
    if (halted !== 1'b0 || state_o !== 3'b000) begin
      n_fail++; $display("FAIL halt_rst got h=%b st=%b want 0/000", halted, state_o);
    end
    #1; RST = 1'b0; exp_cnt = 0;
    op = 6'b010101; mem_ready = 1;
    tick(); tick();
    n_chk++;
    if ({state_o, halted, illegal} !== {3'b101, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ill_op got st=%b h=%b ill=%b want 101/1/1", state_o, halted, illegal);
    end
    RST = 1'b1; #1;
    n_chk++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL ill_clr got %b want 0", illegal);
    end
    #1; RST = 1'b0;
    op = 6'b000000; func = 6'b111111;
    tick(); tick();
    n_chk++;
    if ({state_o, illegal} !== {3'b101, 1'b1}) begin
      n_fail++; $display("FAIL ill_func got st=%b ill=%b want 101/1", state_o, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rst_mid_exe();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_alu_ops();
    test_rst_mid_mem();
    test_saturation();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
